// File: rtl/oric_sdram_pkg.sv
// rtl/oric_sdram_pkg.sv - shared types and helpers for the Oric SDRAM port scheduler
package oric_sdram_pkg;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_CPU_WAIT = 2'd1,
        S_LD_WAIT  = 2'd2
    } sched_state_t;

    // Reads fetch the whole word; the byte is picked on return.
    localparam logic [1:0] DS_RD = 2'b11;

    // Write byte enables: odd address -> upper byte lane.
    function automatic logic [1:0] ds_wr(input logic a0);
        return {a0, ~a0};
    endfunction

endpackage

// File: rtl/oric_cpu_evt_det.sv
// rtl/oric_cpu_evt_det.sv - CPU bus access event detector with one-deep pending latch
module oric_cpu_evt_det (
    input  logic        clk_72,
    input  logic        reset,
    input  logic        cpu_cs,
    input  logic        cpu_oe,
    input  logic        cpu_we,
    input  logic [15:0] cpu_ad,
    input  logic [7:0]  cpu_d,
    input  logic        take,
    output logic        pend,
    output logic [15:0] pend_ad,
    output logic [7:0]  pend_d,
    output logic        pend_we
);

    logic        prev_rd;
    logic        prev_wr;
    logic [15:0] prev_ad;
    logic        cur_rd;
    logic        cur_wr;
    logic        rise_wr;
    logic        evt;

    assign cur_rd  = cpu_cs & cpu_oe;
    assign cur_wr  = cpu_cs & cpu_we;
    assign rise_wr = cur_wr & ~prev_wr;
    assign evt     = (cur_rd & ~prev_rd) | rise_wr | (cur_rd & (cpu_ad != prev_ad));

    // Previous-cycle bus snapshot; keeps tracking during reset so strobes held across it do not fire on release.
    always_ff @(posedge clk_72) begin
        prev_rd <= cur_rd;
        prev_wr <= cur_wr;
        prev_ad <= cpu_ad;
    end

    // Pending access latch; latest event wins, and an event beats a take in the same cycle.
    always_ff @(posedge clk_72) begin
        if (reset) begin
            pend    <= 1'b0;
            pend_ad <= 16'h0000;
            pend_d  <= 8'h00;
            pend_we <= 1'b0;
        end else if (evt) begin
            pend    <= 1'b1;
            pend_ad <= cpu_ad;
            pend_d  <= cpu_d;
            pend_we <= rise_wr;
        end else if (take) begin
            pend    <= 1'b0;
        end
    end

endmodule

// File: rtl/oric_sdram_sched.sv
// rtl/oric_sdram_sched.sv - CPU/loader arbiter onto one toggle-handshake SDRAM port (optional SDRAM_SCHED_STATS_EN counters)
module oric_sdram_sched
    import oric_sdram_pkg::*;
#(
    parameter int AW      = 25,
    parameter int TIMEOUT = 255
) (
    input  logic          clk_72,
    input  logic          reset,
    input  logic          cpu_cs,
    input  logic          cpu_oe,
    input  logic          cpu_we,
    input  logic [15:0]   cpu_ad,
    input  logic [7:0]    cpu_d,
    output logic [7:0]    cpu_q,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [7:0]    ld_d,
    output logic [7:0]    ld_q,
    output logic          ld_done,
    output logic          sd_req,
    input  logic          sd_ack,
    output logic [AW-1:0] sd_a,
    output logic [1:0]    sd_ds,
    output logic          sd_we,
    output logic [15:0]   sd_d,
    input  logic [15:0]   sd_q,
    output logic          busy,
    output logic          timeout_err
`ifdef SDRAM_SCHED_STATS_EN
    ,
    output logic [15:0]   cpu_cnt,
    output logic [15:0]   ld_cnt
`endif
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    sched_state_t state;
    sched_state_t state_nxt;
    logic         issue_cpu;
    logic         issue_ld;
    logic         fin;
    logic         tmo;
    logic         ack_match;
    logic [7:0]   to_cnt;
    logic [7:0]   rd_byte;
    logic         pend;
    logic         pend_we;
    logic [15:0]  pend_ad;
    logic [7:0]   pend_d;

    oric_cpu_evt_det u_evt (
        .clk_72  (clk_72),
        .reset   (reset),
        .cpu_cs  (cpu_cs),
        .cpu_oe  (cpu_oe),
        .cpu_we  (cpu_we),
        .cpu_ad  (cpu_ad),
        .cpu_d   (cpu_d),
        .take    (issue_cpu),
        .pend    (pend),
        .pend_ad (pend_ad),
        .pend_d  (pend_d),
        .pend_we (pend_we)
    );

    assign ack_match = (sd_ack == sd_req);
    assign rd_byte   = sd_a[0] ? sd_q[15:8] : sd_q[7:0];
    assign busy      = (state != S_IDLE);

    // Arbitration and completion decode; CPU always beats the loader in IDLE.
    always_comb begin
        state_nxt = state;
        issue_cpu = 1'b0;
        issue_ld  = 1'b0;
        fin       = 1'b0;
        tmo       = 1'b0;
        case (state)
            S_IDLE: begin
                if (pend) begin
                    issue_cpu = 1'b1;
                    state_nxt = S_CPU_WAIT;
                end else if (ld_valid) begin
                    issue_ld  = 1'b1;
                    state_nxt = S_LD_WAIT;
                end
            end
            S_CPU_WAIT, S_LD_WAIT: begin
                if (ack_match) begin
                    fin       = 1'b1;
                    state_nxt = S_IDLE;
                end else if (to_cnt == TO_LAST) begin
                    tmo       = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_72) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Request issue, ack timeout, read-data capture and handshake pulses.
    always_ff @(posedge clk_72) begin
        if (reset) begin
            sd_req      <= sd_ack;
            sd_a        <= '0;
            sd_ds       <= DS_RD;
            sd_we       <= 1'b0;
            sd_d        <= 16'h0000;
            cpu_q       <= 8'h00;
            ld_q        <= 8'h00;
            ld_ready    <= 1'b0;
            ld_done     <= 1'b0;
            timeout_err <= 1'b0;
            to_cnt      <= 8'h00;
        end else begin
            ld_ready <= issue_ld;
            ld_done  <= (state == S_LD_WAIT) && (fin || tmo);
            if (issue_cpu) begin
                sd_req <= ~sd_req;
                sd_a   <= {{(AW-16){1'b0}}, pend_ad};
                sd_ds  <= pend_we ? ds_wr(pend_ad[0]) : DS_RD;
                sd_we  <= pend_we;
                sd_d   <= {pend_d, pend_d};
                to_cnt <= 8'h00;
            end else if (issue_ld) begin
                sd_req <= ~sd_req;
                sd_a   <= ld_addr;
                sd_ds  <= ld_we ? ds_wr(ld_addr[0]) : DS_RD;
                sd_we  <= ld_we;
                sd_d   <= {ld_d, ld_d};
                to_cnt <= 8'h00;
            end else if (busy && !fin && !tmo) begin
                to_cnt <= to_cnt + 8'h01;
            end
            if (tmo) begin
                timeout_err <= 1'b1;
                sd_req      <= sd_ack;
            end
            if (fin && !sd_we) begin
                if (state == S_CPU_WAIT) cpu_q <= rd_byte;
                else                     ld_q  <= rd_byte;
            end
        end
    end

`ifdef SDRAM_SCHED_STATS_EN
    // Completed-access counters, free-running with wrap.
    always_ff @(posedge clk_72) begin
        if (reset) begin
            cpu_cnt <= 16'h0000;
            ld_cnt  <= 16'h0000;
        end else if (fin) begin
            if (state == S_CPU_WAIT) cpu_cnt <= cpu_cnt + 16'h0001;
            else                     ld_cnt  <= ld_cnt + 16'h0001;
        end
    end
`endif

endmodule
